// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// default widths / reset vector.
package fetch_pkg;

    localparam int unsigned AddrWidthDef   = 8;
    localparam int unsigned DataWidthDef   = 16;
    localparam int unsigned ResetVectorDef = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StValid = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: branch load takes priority over a wrapping increment;
// asynchronously resets to ResetVector.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int unsigned AddrWidth   = AddrWidthDef,
    parameter int unsigned ResetVector = ResetVectorDef
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [AddrWidth-1:0] load_addr_i,
    input  logic                 inc_i,
    output logic [AddrWidth-1:0] pc_o
);

    logic [AddrWidth-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + AddrWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= AddrWidth'(ResetVector);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage for a synchronous single-port program memory.
// Define FETCH_PREFETCH_EN to re-read the next word every cycle in VALID (1 instr/cycle).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned AddrWidth   = AddrWidthDef,
    parameter int unsigned DataWidth   = DataWidthDef,
    parameter int unsigned ResetVector = ResetVectorDef
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 run_i,
    input  logic                 branch_load_i,
    input  logic [AddrWidth-1:0] branch_addr_i,
    input  logic                 instr_ready_i,
    input  logic [DataWidth-1:0] mem_data_i,
    output logic [AddrWidth-1:0] address_o,
    output logic                 mem_en_o,
    output logic                 write_en_o,
    output logic [DataWidth-1:0] instr_o,
    output logic [AddrWidth-1:0] instr_pc_o,
    output logic                 instr_valid_o
);

    fetch_state_e         state_d, state_q;
    logic [AddrWidth-1:0] address_d, address_q;
    logic                 mem_en_d, mem_en_q;
    logic [DataWidth-1:0] instr_d, instr_q;
    logic [AddrWidth-1:0] instr_pc_d, instr_pc_q;
    logic                 valid_d, valid_q;
    logic                 pc_inc;
    logic [AddrWidth-1:0] pc;

    fetch_pc #(
        .AddrWidth  (AddrWidth),
        .ResetVector(ResetVector)
    ) u_fetch_pc (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (branch_load_i),
        .load_addr_i(branch_addr_i),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        mem_en_d   = mem_en_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        pc_inc     = 1'b0;

        // A redirect discards any in-flight read: the capture below never happens.
        if (branch_load_i) begin
            valid_d = 1'b0;
            if (run_i) begin
                state_d   = StIssue;
                address_d = branch_addr_i;
                mem_en_d  = 1'b0;
            end else begin
                state_d  = StIdle;
                mem_en_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run_i) begin
                        state_d   = StIssue;
                        address_d = pc;
                        mem_en_d  = 1'b0;
                    end
                end
                StIssue: begin
                    instr_d    = mem_data_i;
                    instr_pc_d = pc;
                    pc_inc     = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = StValid;
`ifdef FETCH_PREFETCH_EN
                    address_d  = pc + AddrWidth'(1);
                    mem_en_d   = 1'b0;
`else
                    mem_en_d   = 1'b1;
`endif
                end
                StValid: begin
                    if (instr_ready_i) begin
                        if (run_i) begin
`ifdef FETCH_PREFETCH_EN
                            // Memory already holds word PC from the held address.
                            instr_d    = mem_data_i;
                            instr_pc_d = pc;
                            pc_inc     = 1'b1;
                            address_d  = pc + AddrWidth'(1);
                            mem_en_d   = 1'b0;
`else
                            state_d    = StIssue;
                            valid_d    = 1'b0;
                            address_d  = pc;
                            mem_en_d   = 1'b0;
`endif
                        end else begin
                            state_d  = StIdle;
                            valid_d  = 1'b0;
                            mem_en_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = StIdle;
                    valid_d  = 1'b0;
                    mem_en_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            address_q  <= AddrWidth'(ResetVector);
            mem_en_q   <= 1'b1;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            mem_en_q   <= mem_en_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign address_o     = address_q;
    assign mem_en_o      = mem_en_q;
    assign write_en_o    = 1'b1;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit with a behavioural 256x16 synchronous memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        branch_load = 1'b0;
    logic [7:0]  branch_addr = 8'h00;
    logic        instr_ready = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [7:0]  address;
    logic        mem_en;
    logic        write_en;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;

    logic [15:0] mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        we_seen_low = 1'b0;

    fetch_unit u_dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .run_i        (run),
        .branch_load_i(branch_load),
        .branch_addr_i(branch_addr),
        .instr_ready_i(instr_ready),
        .mem_data_i   (mem_data),
        .address_o    (address),
        .mem_en_o     (mem_en),
        .write_en_o   (write_en),
        .instr_o      (instr),
        .instr_pc_o   (instr_pc),
        .instr_valid_o(instr_valid)
    );

    always #5 clk = ~clk;

    // Memory samples address/enable on the negedge between fetch posedges.
    always @(negedge clk) begin
        if (!mem_en) mem_data <= mem[address];
        if (write_en !== 1'b1) we_seen_low <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] ins,
                             input logic [7:0] pc);
        check_eq({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
        if (v) begin
            check_eq({tag, ".instr"}, {16'd0, instr}, {16'd0, ins});
            check_eq({tag, ".pc"}, {24'd0, instr_pc}, {24'd0, pc});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        mem[3] = 16'h4444;

        // Reset state
        tick();
        tick();
        check_eq("rst.address", {24'd0, address}, 32'h0);
        check_eq("rst.mem_en", {31'd0, mem_en}, 32'h1);
        check_eq("rst.write_en", {31'd0, write_en}, 32'h1);
        check_eq("rst.instr", {16'd0, instr}, 32'h0);
        check_eq("rst.instr_pc", {24'd0, instr_pc}, 32'h0);
        check_eq("rst.valid", {31'd0, instr_valid}, 32'h0);

        run = 1'b1;
        instr_ready = 1'b1;
        rst_n = 1'b1;

`ifdef FETCH_PREFETCH_EN
        tick();
        check_eq("pf.issue.mem_en", {31'd0, mem_en}, 32'h0);
        check_eq("pf.issue.valid", {31'd0, instr_valid}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("pf.stream", 1'b1, mem[k], 8'(k));
            check_eq("pf.stream.mem_en", {31'd0, mem_en}, 32'h0);
            check_eq("pf.stream.address", {24'd0, address}, 32'(k + 1));
        end
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("pf.stall", 1'b1, 16'h4444, 8'h03);
            check_eq("pf.stall.mem_en", {31'd0, mem_en}, 32'h0);
        end
        instr_ready = 1'b1;
        tick();
        check_out("pf.resume", 1'b1, 16'hA004, 8'h04);
`else
        // Leaving IDLE, then first instruction two posedges later
        tick();
        check_eq("issue0.valid", {31'd0, instr_valid}, 32'h0);
        check_eq("issue0.mem_en", {31'd0, mem_en}, 32'h0);
        check_eq("issue0.address", {24'd0, address}, 32'h0);
        tick();
        check_out("fetch0", 1'b1, 16'h1111, 8'h00);
        check_eq("fetch0.mem_en", {31'd0, mem_en}, 32'h1);
        tick();
        check_eq("issue1.valid", {31'd0, instr_valid}, 32'h0);
        tick();
        check_out("fetch1", 1'b1, 16'h2222, 8'h01);

        // Stall at Instr_PC=1
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check_out("stall", 1'b1, 16'h2222, 8'h01);
        check_eq("stall.mem_en", {31'd0, mem_en}, 32'h1);
        instr_ready = 1'b1;
        tick();
        check_eq("resume.address", {24'd0, address}, 32'h2);
        tick();
        check_out("fetch2", 1'b1, 16'h3333, 8'h02);
        tick();
        tick();
        check_out("fetch3", 1'b1, 16'h4444, 8'h03);

        // Redirect together with a handshake
        branch_load = 1'b1;
        branch_addr = 8'h80;
        tick();
        branch_load = 1'b0;
        check_eq("br80.valid", {31'd0, instr_valid}, 32'h0);
        check_eq("br80.address", {24'd0, address}, 32'h80);
        check_eq("br80.mem_en", {31'd0, mem_en}, 32'h0);
        tick();
        check_out("br80.fetch", 1'b1, 16'hA080, 8'h80);

        // Wrap from 0xFF to 0x00
        branch_load = 1'b1;
        branch_addr = 8'hFF;
        tick();
        branch_load = 1'b0;
        check_eq("brff.valid", {31'd0, instr_valid}, 32'h0);
        tick();
        check_out("brff.fetch", 1'b1, 16'hA0FF, 8'hFF);
        tick();
        check_eq("wrap.address", {24'd0, address}, 32'h0);
        tick();
        check_out("wrap.fetch", 1'b1, 16'h1111, 8'h00);

        // Asynchronous reset mid-ISSUE
        tick();
        check_eq("midissue.mem_en", {31'd0, mem_en}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst.mem_en", {31'd0, mem_en}, 32'h1);
        check_eq("arst.address", {24'd0, address}, 32'h0);
        check_eq("arst.valid", {31'd0, instr_valid}, 32'h0);
        check_eq("arst.instr", {16'd0, instr}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rearm.address", {24'd0, address}, 32'h0);
        tick();
        check_out("rearm.fetch", 1'b1, 16'h1111, 8'h00);

        // Run low with handshake drains to IDLE
        run = 1'b0;
        tick();
        check_eq("drain.valid", {31'd0, instr_valid}, 32'h0);
        check_eq("drain.mem_en", {31'd0, mem_en}, 32'h1);
        tick();
        check_eq("idle.valid", {31'd0, instr_valid}, 32'h0);
        check_eq("idle.mem_en", {31'd0, mem_en}, 32'h1);
`endif

        check_eq("write_en_always_high", {31'd0, we_seen_low}, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
